regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: A (ALU writeback) and B (multdiv/load return). Arbitration is round-robin with a valid/ready handshake. The winner's write is registered and presented to the regfile write port one cycle later. Writes to register 0 are suppressed, since $r0 is hardwired to zero. Per-requester 16-bit write counters support debug and performance monitoring.

Parameters:
ADDR_W, 5, register index width (32 registers)
DATA_W, 32, write data width
CNT_W, 16, width of each per-requester write counter

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  reset, asynchronous, active-low
a_valid  in  1  requester A has a write pending
a_reg  in  ADDR_W  requester A destination register
a_data  in  DATA_W  requester A write data
a_ready  out  1  A's write is accepted this cycle
b_valid  in  1  requester B has a write pending
b_reg  in  ADDR_W  requester B destination register
b_data  in  DATA_W  requester B write data
b_ready  out  1  B's write is accepted this cycle
ctrl_writeEnable  out  1  regfile write enable
ctrl_writeReg  out  ADDR_W  regfile write address
data_writeReg  out  DATA_W  regfile write data
cnt_a  out  CNT_W  count of A transfers with nonzero destination
cnt_b  out  CNT_W  count of B transfers with nonzero destination

Behaviour:
- Clocking and reset: one clock, clk. Reset clr_n is asynchronous and active-low. All state updates on the rising edge of clk.
- While clr_n=0:
  - ctrl_writeEnable, ctrl_writeReg, data_writeReg, cnt_a, cnt_b are all 0.
  - last_grant = B, so A wins the first contention after reset.
  - a_ready = b_ready = 0, forced combinationally.
- Transfer definition: a transfer occurs when valid && ready in the same cycle.
- Requester obligation: once valid is asserted, reg, data and valid are held stable until ready. Dropping valid early is a protocol violation and the bench flags it.
- Ready generation: ready is combinational from the valid inputs and the last_grant state. It never depends on same-cycle output-port state. There is no backpressure from the regfile.
- Arbitration (state: last_grant, 1 bit):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant, last_grant holds.
  - last_grant updates to the winner on every transfer.
  - At most one ready is high per cycle.
- Write pipeline, latency 1 cycle from transfer to write port:
  - On a transfer, the next edge loads ctrl_writeReg and data_writeReg from the winner's reg/data.
  - On that same edge, ctrl_writeEnable is set to 1 if the winner's reg != 0, and 0 if reg == 0.
  - With no transfer, ctrl_writeEnable goes to 0 at the next edge; ctrl_writeReg and data_writeReg hold their previous values.
  - Back-to-back transfers produce back-to-back writes, giving full throughput of one write per cycle.
- Register 0:
  - The transfer still completes; ready is asserted normally.
  - No regfile write is issued.
  - The counter does not increment.
  - The round-robin pointer still updates.
- Counters:
  - cnt_a increments on each A transfer with a_reg != 0; cnt_b likewise for B.
  - Both wrap from 2^CNT_W-1 to 0 with no saturation.
- Simultaneous same-destination writes: A and B both targeting the same register are serialized in grant order. The later grant's data is the final regfile value. No merging and no reordering.
- Reset mid-operation:
  - Asserting clr_n clears ctrl_writeEnable immediately (asynchronously), so an in-flight write is lost.
  - Requesters must re-present pending writes after reset.
  - On the first edge after deassertion, normal arbitration resumes with A favoured.

Test Plan:
- Reset: hold clr_n=0 with a_valid=b_valid=1 -> a_ready=b_ready=0, all outputs 0. Release, then both valid -> a_ready=1 in the first cycle. Next edge: ctrl_writeEnable=1, ctrl_writeReg=a_reg.
- Single requester stream: B only, writes r5=0x11, r6=0x22, r7=0x33 on consecutive cycles -> b_ready=1 each cycle. Writes appear at cycles +1, +2, +3 with matching reg/data. cnt_b=3.
- Contention alternation: A (r1, 0xAAAA0001) and B (r2, 0xBBBB0002) both valid for 4 cycles -> grant order A,B,A,B. ctrl_writeReg sequence 1,2,1,2 with matching data. cnt_a=2, cnt_b=2.
- Register 0: A writes r0=0xDEADBEEF -> a_ready=1. Next cycle ctrl_writeEnable=0 and cnt_a unchanged. A following B contention is granted to B (last_grant=A).
- Same destination: A r9=0x1 and B r9=0x2 both valid with last_grant=A -> B written first (0x2), then A (0x1). Final write data 0x1.
- Counter wrap and async reset: preload cnt_a to 0xFFFF via 65535 transfers, then one more -> cnt_a=0x0000. Assert clr_n mid-cycle during a pending write -> ctrl_writeEnable drops to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter between two writeback requesters sharing one regfile write port.
module regfile_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);
  logic              last_b;
  logic              grant_a;
  logic              grant_b;
  logic              xfer;
  logic              nz;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;
  always_comb begin
    grant_a  = clr_n && a_valid && (!b_valid || last_b);
    grant_b  = clr_n && b_valid && !grant_a;
    xfer     = grant_a || grant_b;
    win_reg  = grant_a ? a_reg : b_reg;
    win_data = grant_a ? a_data : b_data;
    nz       = |win_reg;
  end
  assign a_ready = grant_a;
  assign b_ready = grant_b;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      last_b           <= 1'b1;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      cnt_a            <= '0;
      cnt_b            <= '0;
    end else begin
      ctrl_writeEnable <= xfer && nz;
      if (xfer) begin
        ctrl_writeReg <= win_reg;
        data_writeReg <= win_data;
        last_b        <= grant_b;
      end
      if (grant_a && nz) cnt_a <= cnt_a + 1'b1;
      if (grant_b && nz) cnt_b <= cnt_b + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random checks of the write arbiter against a transfer-level model.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        clr_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_reg, b_reg, ctrl_writeReg;
  logic [31:0] a_data, b_data, data_writeReg;
  logic        ctrl_writeEnable;
  logic [15:0] cnt_a, cnt_b;
  int          errors = 0;
  int          checks = 0;
  bit          m_we, m_fav_a, got_a, got_b;
  int          m_reg, m_ca, m_cb;
  logic [31:0] m_data;

  regfile_write_arbiter dut (
    .clk(clk), .clr_n(clr_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_we = 0; m_reg = 0; m_data = 0; m_ca = 0; m_cb = 0; m_fav_a = 1;
  endtask

  // One clock: check readies against the model, apply the transfer, check the registered write.
  task automatic cycle();
    bit wa, wb;
    int r;
    #1;
    wa = clr_n && a_valid && (!b_valid || m_fav_a);
    wb = clr_n && b_valid && !wa;
    check("a_ready", a_ready, wa);
    check("b_ready", b_ready, wb);
    got_a = wa;
    got_b = wb;
    if (wa || wb) begin
      r = wa ? int'(a_reg) : int'(b_reg);
      m_we = (r != 0);
      m_reg = r;
      m_data = wa ? a_data : b_data;
      if (r != 0 && wa) m_ca = (m_ca + 1) % 65536;
      if (r != 0 && wb) m_cb = (m_cb + 1) % 65536;
      m_fav_a = wb;
    end else m_we = 0;
    @(posedge clk);
    #1;
    check("write_enable", ctrl_writeEnable, m_we);
    check("write_reg", ctrl_writeReg, m_reg[4:0]);
    check("write_data", data_writeReg, m_data);
    check("cnt_a", cnt_a, m_ca[15:0]);
    check("cnt_b", cnt_b, m_cb[15:0]);
  endtask

  task automatic send(input bit av, input int ar, input logic [31:0] ad,
                      input bit bv, input int br, input logic [31:0] bd);
    a_valid = av; a_reg = 5'(ar); a_data = ad;
    b_valid = bv; b_reg = 5'(br); b_data = bd;
    cycle();
  endtask

  initial begin
    clr_n = 0; a_valid = 1; b_valid = 1;
    a_reg = 5'd3; a_data = 32'h1234_5678; b_reg = 5'd4; b_data = 32'h8765_4321;
    model_reset();
    #12;
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_we", ctrl_writeEnable, 1'b0);
    check("rst_reg", ctrl_writeReg, 5'd0);
    check("rst_data", data_writeReg, 32'd0);
    check("rst_cnt_a", cnt_a, 16'd0);
    check("rst_cnt_b", cnt_b, 16'd0);
    clr_n = 1;
    cycle();
    check("first_grant_a", got_a, 1'b1);
    send(0, 0, 0, 0, 0, 0);
    send(0, 0, 0, 1, 5, 32'h11);
    send(0, 0, 0, 1, 6, 32'h22);
    send(0, 0, 0, 1, 7, 32'h33);
    check("stream_cnt_b", cnt_b, 16'd3);
    send(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      send(1, 1, 32'hAAAA_0001, 1, 2, 32'hBBBB_0002);
      check("alt_reg", ctrl_writeReg, (i % 2 == 0) ? 5'd1 : 5'd2);
    end
    check("alt_cnt_a", cnt_a, 16'd3);
    check("alt_cnt_b", cnt_b, 16'd5);
    send(1, 0, 32'hDEAD_BEEF, 0, 0, 0);
    check("r0_we", ctrl_writeEnable, 1'b0);
    check("r0_cnt_a", cnt_a, 16'd3);
    send(1, 8, 32'h5, 1, 8, 32'h6);
    check("r0_then_b", got_b, 1'b1);
    send(1, 3, 32'h7, 0, 0, 0);
    send(1, 9, 32'h1, 1, 9, 32'h2);
    check("same_first_data", data_writeReg, 32'h2);
    send(1, 9, 32'h1, 0, 0, 0);
    check("same_final_data", data_writeReg, 32'h1);
    send(0, 0, 0, 0, 0, 0);
    a_valid = 0; b_valid = 0;
    for (int i = 0; i < 300; i++) begin
      if (!a_valid || got_a) begin
        a_valid = 1'($urandom_range(0, 1)); a_reg = 5'($urandom_range(0, 31)); a_data = $urandom;
      end
      if (!b_valid || got_b) begin
        b_valid = 1'($urandom_range(0, 1)); b_reg = 5'($urandom_range(0, 31)); b_data = $urandom;
      end
      got_a = 0; got_b = 0;
      cycle();
    end
    a_valid = 1; b_valid = 0; a_reg = 5'($urandom_range(1, 31)); a_data = $urandom;
    while (m_ca != 65535) cycle();
    check("wrap_pre", cnt_a, 16'hFFFF);
    cycle();
    check("wrap_zero", cnt_a, 16'h0000);
    send(1, 4, 32'hCAFE_F00D, 0, 0, 0);
    check("async_we_before", ctrl_writeEnable, 1'b1);
    a_valid = 0;
    #2;
    clr_n = 0;
    #1;
    check("async_we_drop", ctrl_writeEnable, 1'b0);
    check("async_cnt_a", cnt_a, 16'd0);
    model_reset();
    #3;
    clr_n = 1;
    send(1, 10, 32'h77, 1, 11, 32'h88);
    check("post_rst_grant_a", got_a, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
